// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and anything that drives it.
package mdu_pkg;

    // Op field encodings, as decoded from MULT/MULTU/DIV/DIVU
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // One iteration per result bit; WIDTH is expected to equal this
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } stateT;

    // Signed variants work on magnitudes and re-apply the sign in FIX
    function automatic logic opSigned(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic opIsDiv(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational two's-complement negate-on-request; used for operand
// magnitudes at Start and for re-applying result signs in FIX.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] Value,
    input  logic         Negate,
    output logic [W-1:0] Result
);

    assign Result = Negate ? -Value : Value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle multiply/divide unit holding the architectural HI/LO
// registers. Busy freezes the PC while an operation is in flight.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             HiWre,
    input  logic             LoWre,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

    stateT              state;
    logic [CNT_W-1:0]   count;
    logic               opDiv;
    logic               negResult;   // operand signs differ (signed ops only)
    logic               negRem;      // dividend was negative (DIV only)
    logic               divZero;
    logic [WIDTH-1:0]   operandB;    // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;         // mul: {partial, multiplier}; div: {rem, quot}
    logic [2*WIDTH-1:0] accNext;

    logic               signedOp;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [2*WIDTH-1:0] prodFixed;
    logic [WIDTH-1:0]   quotFixed;
    logic [WIDTH-1:0]   remFixed;

    logic [WIDTH-1:0]   mulAddend;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     remShift;

    assign signedOp = opSigned(Op);

    mdu_sign_fix #(.W(WIDTH)) uAbsA (
        .Value  (SrcA),
        .Negate (signedOp & SrcA[WIDTH-1]),
        .Result (absA)
    );

    mdu_sign_fix #(.W(WIDTH)) uAbsB (
        .Value  (SrcB),
        .Negate (signedOp & SrcB[WIDTH-1]),
        .Result (absB)
    );

    mdu_sign_fix #(.W(2*WIDTH)) uFixProd (
        .Value  (acc),
        .Negate (negResult),
        .Result (prodFixed)
    );

    // Divide by zero keeps the all-ones quotient regardless of operand signs
    mdu_sign_fix #(.W(WIDTH)) uFixQuot (
        .Value  (acc[WIDTH-1:0]),
        .Negate (negResult & ~divZero),
        .Result (quotFixed)
    );

    // Remainder follows the dividend sign; for x/0 this restores the original dividend
    mdu_sign_fix #(.W(WIDTH)) uFixRem (
        .Value  (acc[2*WIDTH-1:WIDTH]),
        .Negate (negRem),
        .Result (remFixed)
    );

    // One shift-add (multiply) or restoring-subtract (divide) step
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        accNext   = acc;
        mulAddend = '0;
        mulSum    = '0;
        remShift  = '0;
        if (opDiv) begin
            remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
            if (remShift >= {1'b0, operandB}) begin
                accNext = {remShift[WIDTH-1:0] - operandB, acc[WIDTH-2:0], 1'b1};
            end else begin
                accNext = {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            mulAddend = acc[0] ? operandB : '0;
            mulSum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mulAddend};
            accNext   = {mulSum, acc[WIDTH-1:1]};
        end
    end

    // Control FSM, iteration counter, datapath registers and HI/LO
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!RST) begin
            state     <= ST_IDLE;
            count     <= '0;
            opDiv     <= 1'b0;
            negResult <= 1'b0;
            negRem    <= 1'b0;
            divZero   <= 1'b0;
            operandB  <= '0;
            acc       <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        opDiv     <= opIsDiv(Op);
                        negResult <= signedOp & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                        negRem    <= signedOp & SrcA[WIDTH-1];
                        divZero   <= (SrcB == '0);
                        operandB  <= opIsDiv(Op) ? absB : absA;
                        acc       <= {{WIDTH{1'b0}}, (opIsDiv(Op) ? absA : absB)};
                        count     <= '0;
                        Busy      <= 1'b1;
                        state     <= ST_CALC;
                    end else begin
                        if (HiWre) Hi <= WriteData;
                        if (LoWre) Lo <= WriteData;
                    end
                end
                ST_CALC: begin
                    acc   <= accNext;
                    count <= count + CNT_W'(1);
                    if (count == LAST_ITER) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (opDiv) begin
                        Hi <= remFixed;
                        Lo <= quotFixed;
                    end else begin
                        Hi <= prodFixed[2*WIDTH-1:WIDTH];
                        Lo <= prodFixed[WIDTH-1:0];
                    end
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
